// File: rtl/riscv_noicache_pf.sv
// riscv_noicache_pf: uncached instruction prefetcher between the IF stage and the BIU.
// Keeps up to MAX_OUTSTANDING single reads in flight and queues returned words in a circular FIFO.
module riscv_noicache_pf #(
    parameter int XLEN            = 32,
    parameter int PHYS_ADDR_SIZE  = XLEN,
    parameter int PARCEL_SIZE     = 32,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      if_stall_nxt_pc,
    input  logic                      if_stall,
    input  logic                      if_flush,
    input  logic [XLEN-1:0]           if_nxt_pc,
    output logic [XLEN-1:0]           if_parcel_pc,
    output logic [PARCEL_SIZE-1:0]    if_parcel,
    output logic                      if_parcel_valid,
    output logic                      if_parcel_misaligned,
    output logic                      if_parcel_error,
    input  logic                      dcflush_rdy,
    input  logic [1:0]                st_prv,
    output logic                      biu_stb,
    input  logic                      biu_stb_ack,
    output logic [PHYS_ADDR_SIZE-1:0] biu_adri,
    input  logic [PHYS_ADDR_SIZE-1:0] biu_adro,
    output logic [XLEN/8-1:0]         biu_be,
    output logic [2:0]                biu_type,
    output logic                      biu_we,
    input  logic [XLEN-1:0]           biu_do,
    input  logic                      biu_rack,
    input  logic                      biu_err,
    output logic                      biu_is_cacheable,
    output logic                      biu_is_instruction,
    output logic [1:0]                biu_prv
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = PW - 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(XLEN / 32) + 1;
    localparam int EW = 1 + PHYS_ADDR_SIZE + XLEN;

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [OW-1:0] CNT_ONE = OW'(1);

    logic [EW-1:0]             r_mem [DEPTH];
    logic [PW-1:0]             r_wr_ptr;
    logic [PW-1:0]             r_rd_ptr;
    logic [OW-1:0]             r_outstanding;
    logic [OW-1:0]             r_discard;
    logic                      r_flush_dly;

    logic                      w_resp;
    logic                      w_issue;
    logic                      w_write;
    logic                      w_empty;
    logic [PW-1:0]             w_count;
    logic [PW:0]               w_credit;
    logic [EW-1:0]             w_head;
    logic                      w_head_err;
    logic [PHYS_ADDR_SIZE-1:0] w_head_adr;
    logic [XLEN-1:0]           w_head_dat;
    logic [SW-1:0]             w_sel;
    logic [XLEN+PARCEL_SIZE-1:0] w_dat_ext;

    // FIFO occupancy and the credit that bounds issue
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_credit = (PW+1)'(r_outstanding) + (PW+1)'(w_count);

    assign w_resp  = biu_rack | biu_err;
    assign w_issue = biu_stb & biu_stb_ack;
    assign w_write = w_resp & (r_discard == '0) & ~if_flush;

    // Strobe is gated by rst so nothing leaves the block while reset is held
    assign biu_stb = ~rst & dcflush_rdy & ~if_flush & ~if_stall
                   & (r_outstanding < OW'(MAX_OUTSTANDING))
                   & (w_credit < (PW+1)'(DEPTH));

    assign if_stall_nxt_pc    = ~biu_stb | ~biu_stb_ack;
    assign biu_adri           = if_nxt_pc[PHYS_ADDR_SIZE-1:0];
    assign biu_is_cacheable   = ~if_nxt_pc[PHYS_ADDR_SIZE-1];
    assign biu_be             = '1;
    assign biu_type           = 3'h0;
    assign biu_we             = 1'b0;
    assign biu_is_instruction = 1'b1;
    assign biu_prv            = st_prv;

    assign w_head                               = r_mem[r_rd_ptr[AW-1:0]];
    assign {w_head_err, w_head_adr, w_head_dat} = w_head;

    assign if_parcel_valid      = dcflush_rdy & ~if_flush & ~r_flush_dly & ~if_stall & ~w_empty;
    assign if_parcel_pc         = XLEN'(w_head_adr);
    assign if_parcel_misaligned = |if_parcel_pc[1:0];
    assign if_parcel_error      = w_head_err;

    // Zero padding above the word keeps the halfword-indexed slice in range
    assign w_sel     = if_parcel_pc[SW:1];
    assign w_dat_ext = {{PARCEL_SIZE{1'b0}}, w_head_dat};
    assign if_parcel = PARCEL_SIZE'(w_dat_ext >> {w_sel, 4'b0000});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_flush_dly   <= 1'b0;
        end else begin
            r_flush_dly <= if_flush;

            if (w_issue && !w_resp) begin
                r_outstanding <= r_outstanding + CNT_ONE;
            end else if (!w_issue && w_resp) begin
                r_outstanding <= r_outstanding - CNT_ONE;
            end

            if (if_flush) begin
                // Every request still owed by the bus, minus one answered now, gets dropped
                r_rd_ptr  <= r_wr_ptr;
                r_discard <= (w_resp && r_outstanding != '0) ? r_outstanding - CNT_ONE
                                                             : r_outstanding;
            end else begin
                if (w_write) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (if_parcel_valid) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
                if (w_resp && r_discard != '0) begin
                    r_discard <= r_discard - CNT_ONE;
                end
            end
        end
    end

    // NOTE: storage carries no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {biu_err, biu_adro, biu_do};
        end
    end

endmodule

// File: tb/tb_riscv_noicache_pf.sv
// tb_riscv_noicache_pf: directed bench with an in-order BIU model of configurable latency.
// A 32-bit instance runs the flow tests; a 64-bit instance checks parcel selection.
module tb_riscv_noicache_pf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_stall_nxt_pc, if_stall, if_flush;
    logic [31:0] if_nxt_pc, if_parcel_pc, if_parcel;
    logic        if_parcel_valid, if_parcel_misaligned, if_parcel_error;
    logic        dcflush_rdy;
    logic [1:0]  st_prv;
    logic        biu_stb, biu_stb_ack;
    logic [31:0] biu_adri, biu_adro, biu_do;
    logic [3:0]  biu_be;
    logic [2:0]  biu_type;
    logic        biu_we, biu_rack, biu_err, biu_is_cacheable, biu_is_instruction;
    logic [1:0]  biu_prv;

    logic        if_stall_nxt_pc_w, if_stall_w, if_flush_w;
    logic [63:0] if_nxt_pc_w, if_parcel_pc_w;
    logic [31:0] if_parcel_w;
    logic        if_parcel_valid_w, if_parcel_misaligned_w, if_parcel_error_w;
    logic        dcflush_rdy_w;
    logic [1:0]  st_prv_w;
    logic        biu_stb_w, biu_stb_ack_w;
    logic [63:0] biu_adri_w, biu_adro_w, biu_do_w;
    logic [7:0]  biu_be_w;
    logic [2:0]  biu_type_w;
    logic        biu_we_w, biu_rack_w, biu_err_w, biu_is_cacheable_w, biu_is_instruction_w;
    logic [1:0]  biu_prv_w;

    riscv_noicache_pf #(.XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2)) u_dut (
        .clk(clk), .rst(rst),
        .if_stall_nxt_pc(if_stall_nxt_pc), .if_stall(if_stall), .if_flush(if_flush),
        .if_nxt_pc(if_nxt_pc), .if_parcel_pc(if_parcel_pc), .if_parcel(if_parcel),
        .if_parcel_valid(if_parcel_valid), .if_parcel_misaligned(if_parcel_misaligned),
        .if_parcel_error(if_parcel_error), .dcflush_rdy(dcflush_rdy), .st_prv(st_prv),
        .biu_stb(biu_stb), .biu_stb_ack(biu_stb_ack), .biu_adri(biu_adri), .biu_adro(biu_adro),
        .biu_be(biu_be), .biu_type(biu_type), .biu_we(biu_we), .biu_do(biu_do),
        .biu_rack(biu_rack), .biu_err(biu_err), .biu_is_cacheable(biu_is_cacheable),
        .biu_is_instruction(biu_is_instruction), .biu_prv(biu_prv)
    );

    riscv_noicache_pf #(.XLEN(64), .DEPTH(4), .MAX_OUTSTANDING(2)) u_dut64 (
        .clk(clk), .rst(rst),
        .if_stall_nxt_pc(if_stall_nxt_pc_w), .if_stall(if_stall_w), .if_flush(if_flush_w),
        .if_nxt_pc(if_nxt_pc_w), .if_parcel_pc(if_parcel_pc_w), .if_parcel(if_parcel_w),
        .if_parcel_valid(if_parcel_valid_w), .if_parcel_misaligned(if_parcel_misaligned_w),
        .if_parcel_error(if_parcel_error_w), .dcflush_rdy(dcflush_rdy_w), .st_prv(st_prv_w),
        .biu_stb(biu_stb_w), .biu_stb_ack(biu_stb_ack_w), .biu_adri(biu_adri_w),
        .biu_adro(biu_adro_w), .biu_be(biu_be_w), .biu_type(biu_type_w), .biu_we(biu_we_w),
        .biu_do(biu_do_w), .biu_rack(biu_rack_w), .biu_err(biu_err_w),
        .biu_is_cacheable(biu_is_cacheable_w), .biu_is_instruction(biu_is_instruction_w),
        .biu_prv(biu_prv_w)
    );

    typedef struct {
        logic [31:0] adr;
        int          due;
    } req_t;

    req_t        pend[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          issued = 0;
    int          popped = 0;
    int          err_seen = 0;
    int          first_cyc = -1;
    int          mark_iss, mark_pop;
    logic        want_first = 1'b0;
    logic [31:0] first_pc = 32'hFFFF_FFFF;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] err_adr = 32'hFFFF_FFFF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // One clock of the 32-bit flow: drive the BIU response, sample at negedge+1, advance.
    task automatic cycle();
        biu_rack = 1'b0;
        biu_err  = 1'b0;
        biu_adro = 32'h0;
        biu_do   = 32'h0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            biu_adro = pend[0].adr;
            biu_do   = data_of(pend[0].adr);
            if (pend[0].adr == err_adr) biu_err = 1'b1;
            else                        biu_rack = 1'b1;
            pend.delete(0);
        end
        #1;
        if (if_parcel_valid) begin
            if (want_first) begin
                first_pc   = if_parcel_pc;
                first_cyc  = cyc;
                want_first = 1'b0;
            end
            check("parcel_pc", if_parcel_pc, exp_pc);
            check("parcel_dat", if_parcel, data_of(exp_pc));
            check("parcel_err", if_parcel_error, exp_pc == err_adr);
            check("parcel_mis", if_parcel_misaligned, |exp_pc[1:0]);
            if (if_parcel_error) err_seen++;
            exp_pc = exp_pc + 32'd4;
            popped++;
        end
        if (biu_stb && biu_stb_ack) begin
            pend.push_back('{adr: biu_adri, due: cyc + lat});
            issued++;
            if_nxt_pc = if_nxt_pc + 32'd4;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        if_stall = 1'b1; if_flush = 1'b0; if_nxt_pc = 32'h0; dcflush_rdy = 1'b1;
        st_prv = 2'b11; biu_stb_ack = 1'b1; biu_rack = 1'b0; biu_err = 1'b0;
        biu_adro = 32'h0; biu_do = 32'h0;
        if_stall_w = 1'b0; if_flush_w = 1'b0; if_nxt_pc_w = 64'h0; dcflush_rdy_w = 1'b1;
        st_prv_w = 2'b01; biu_stb_ack_w = 1'b0; biu_rack_w = 1'b0; biu_err_w = 1'b0;
        biu_adro_w = 64'h0; biu_do_w = 64'h0;

        #1;
        check("rst_valid", if_parcel_valid, 0);
        check("rst_stb", biu_stb, 0);
        check("rst_hold_pc", if_stall_nxt_pc, 1);
        check("rst_stb64", biu_stb_w, 0);
        check("rst_valid64", if_parcel_valid_w, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("be", biu_be, 4'hF);
        check("type", biu_type, 3'h0);
        check("we", biu_we, 0);
        check("is_instr", biu_is_instruction, 1);
        check("prv", biu_prv, 2'b11);
        check("cacheable", biu_is_cacheable, 1);

        // 64-bit: two back-to-back reads, word-offset and halfword-offset parcels
        if_nxt_pc_w = 64'h1004; biu_stb_ack_w = 1'b1;
        #1;
        check("t5_stb", biu_stb_w, 1);
        check("t5_adri", biu_adri_w, 64'h1004);
        check("t5_advance", if_stall_nxt_pc_w, 0);
        @(posedge clk); @(negedge clk);
        if_nxt_pc_w = 64'h1002; biu_rack_w = 1'b1;
        biu_adro_w = 64'h1004; biu_do_w = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        check("t5_no_bypass", if_parcel_valid_w, 0);
        @(posedge clk); @(negedge clk);
        biu_stb_ack_w = 1'b0; biu_adro_w = 64'h1002;
        #1;
        check("t5_valid0", if_parcel_valid_w, 1);
        check("t5_pc0", if_parcel_pc_w, 64'h1004);
        check("t5_parcel0", if_parcel_w, 32'hAAAA_BBBB);
        check("t5_mis0", if_parcel_misaligned_w, 0);
        check("t5_hold", if_stall_nxt_pc_w, 1);
        @(posedge clk); @(negedge clk);
        biu_rack_w = 1'b0;
        #1;
        check("t5_valid1", if_parcel_valid_w, 1);
        check("t5_pc1", if_parcel_pc_w, 64'h1002);
        check("t5_parcel1", if_parcel_w, 32'hBBBB_CCCC);
        check("t5_mis1", if_parcel_misaligned_w, 1);
        check("t5_err1", if_parcel_error_w, 0);
        @(posedge clk); @(negedge clk);
        if_nxt_pc_w = 64'h8000_0000_0000_0000;
        #1;
        check("t5_empty", if_parcel_valid_w, 0);
        check("t5_noncache", biu_is_cacheable_w, 0);
        check("t5_be", biu_be_w, 8'hFF);
        check("t5_type", biu_type_w, 3'h0);
        check("t5_we", biu_we_w, 0);
        check("t5_instr", biu_is_instruction_w, 1);
        check("t5_prv", biu_prv_w, 2'b01);
        @(negedge clk);

        // Zero-wait stream from 0x0
        if_stall = 1'b0; if_nxt_pc = 32'h0; exp_pc = 32'h0; cyc = 0;
        want_first = 1'b1;
        repeat (10) cycle();
        check("t1_first_cyc", first_cyc, 2);
        check("t1_first_pc", first_pc, 32'h0);
        check("t1_count", popped, 8);

        // Stall: no issue, no pop, then an in-order drain
        mark_iss = issued; mark_pop = popped;
        if_stall = 1'b1;
        repeat (10) cycle();
        check("t2_no_issue", issued - mark_iss, 0);
        check("t2_no_pop", popped - mark_pop, 0);
        if_stall = 1'b0;
        repeat (6) cycle();
        check("t2_drain", exp_pc, 32'h38);

        // Two reads in flight at 0x100/0x104, then flush to 0x200
        lat = 3;
        if_flush = 1'b1; if_nxt_pc = 32'h100; exp_pc = 32'h100;
        cycle();
        if_flush = 1'b0;
        repeat (2) cycle();
        check("t3_inflight", pend.size(), 2);
        if_flush = 1'b1; if_nxt_pc = 32'h200; exp_pc = 32'h200;
        want_first = 1'b1; first_pc = 32'hFFFF_FFFF;
        cycle();
        if_flush = 1'b0;
        repeat (12) cycle();
        check("t3_first", first_pc, 32'h200);

        // Bus error on 0x108 travels with its parcel only
        lat = 1; err_adr = 32'h108; err_seen = 0;
        if_flush = 1'b1; if_nxt_pc = 32'h108; exp_pc = 32'h108;
        cycle();
        if_flush = 1'b0;
        repeat (14) cycle();
        check("t4_err_cnt", err_seen, 1);
        check("t4_past", exp_pc >= 32'h110, 1);

        // Reset with two requests outstanding
        err_adr = 32'hFFFF_FFFF; lat = 2;
        repeat (2) cycle();
        check("t6_inflight", pend.size(), 2);
        rst = 1'b1; biu_rack = 1'b0; biu_err = 1'b0;
        #1;
        check("t6_stb", biu_stb, 0);
        check("t6_valid", if_parcel_valid, 0);
        check("t6_hold_pc", if_stall_nxt_pc, 1);
        pend.delete();
        @(posedge clk);
        #1;
        check("t6_stb_held", biu_stb, 0);
        @(negedge clk);
        rst = 1'b0; if_nxt_pc = 32'h400; exp_pc = 32'h400; lat = 1;
        mark_pop = popped; want_first = 1'b1; first_pc = 32'hFFFF_FFFF;
        repeat (8) cycle();
        check("t6_first", first_pc, 32'h400);
        check("t6_count", popped - mark_pop, 6);
        check("t6_next", exp_pc, 32'h418);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
